// File: rtl/vec_seq_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_seq_chk_pkg
// Description : Shared types and constants for the exhaustive 4-input vector
//               sequencer/checker. GOLDEN holds the expected response of the
//               gate network y = ~c & ~(a & d), where bit i is the response
//               to the vector {a,b,c,d} == i.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_seq_chk_pkg;

    localparam int unsigned VEC_W   = 4;
    localparam int unsigned NUM_VEC = 16;

    localparam logic [NUM_VEC-1:0] GOLDEN   = 16'h1133;
    localparam logic [VEC_W-1:0]   LAST_IDX = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : vec_seq_chk_pkg
`default_nettype wire

// File: rtl/vec_seq_chk_if.sv
`default_nettype none
// ============================================================================
// Module      : vec_seq_chk_if
// Description : Control, stimulus and result bundle of vec_seq_chk.
//               slave  : the checker (drives stimulus and results)
//               master : the controller / gate network side
// Signals     : start, abort, y                  (master -> slave)
//               a, b, c, d, busy, done, pass,
//               err_cnt, resp, first_fail,
//               first_fail_vld                   (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface vec_seq_chk_if;
    import vec_seq_chk_pkg::*;

    logic               start;
    logic               abort;
    logic               y;
    logic               a;
    logic               b;
    logic               c;
    logic               d;
    logic               busy;
    logic               done;
    logic               pass;
    logic [4:0]         err_cnt;
    logic [NUM_VEC-1:0] resp;
    logic [VEC_W-1:0]   first_fail;
    logic               first_fail_vld;

    modport slave (
        input  start, abort, y,
        output a, b, c, d, busy, done, pass, err_cnt, resp,
               first_fail, first_fail_vld
    );

    modport master (
        output start, abort, y,
        input  a, b, c, d, busy, done, pass, err_cnt, resp,
               first_fail, first_fail_vld
    );

endinterface : vec_seq_chk_if
`default_nettype wire

// File: rtl/vsc_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vsc_settle_cnt
// Description : Down-counter timing the settle window before each sample.
//               load reloads SETTLE-1, tick counts down, expire flags the
//               last settle cycle (count == 0).
// Ports       : clk, rst_n (async, active low), load, tick -> expire
// Revision    : 1.0 - initial release
// ============================================================================
module vsc_settle_cnt #(
    parameter int unsigned SETTLE = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic load,
    input  wire logic tick,
    output logic      expire
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (load) begin
            r_cnt <= 4'(SETTLE - 1);
        end else if (tick && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign expire = (r_cnt == 4'd0);

endmodule : vsc_settle_cnt
`default_nettype wire

// File: rtl/vec_seq_chk.sv
`default_nettype none
// ============================================================================
// Module      : vec_seq_chk
// Description : Applies all 16 vectors {a,b,c,d} to a gate network, waits
//               SETTLE cycles per vector, samples y, and compares it to the
//               golden response. Reports per-vector responses, the mismatch
//               count, a pass flag and a one-cycle done pulse.
// Ports       : clk, rst_n (async, active low)
//               bus (vec_seq_chk_if.slave): start, abort, y in;
//               a..d, busy, done, pass, err_cnt, resp, first_fail,
//               first_fail_vld out
// Options     : VEC_SEQ_CHK_FIRST_FAIL_EN - capture index of first mismatch;
//               when undefined first_fail/first_fail_vld are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_seq_chk
    import vec_seq_chk_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    vec_seq_chk_if.slave   bus
);

    state_t             r_state;
    state_t             w_next;
    logic [VEC_W-1:0]   r_idx;
    logic [4:0]         r_err_cnt;
    logic [NUM_VEC-1:0] r_resp;
    logic               r_pass;
    logic               r_done;
    logic               w_busy;
    logic [VEC_W-1:0]   w_vec;
    logic               w_accept;
    logic               w_sample;
    logic               w_mismatch;
    logic               w_last;
    logic               w_load;
    logic               w_tick;
    logic               w_expire;

    // abort has priority over start in IDLE and over the sample write.
    assign w_accept   = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_sample   = (r_state == ST_SAMPLE) && !bus.abort;
    assign w_mismatch = (bus.y != GOLDEN[r_idx]);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_load     = w_accept || (w_sample && !w_last);
    assign w_tick     = (r_state == ST_SETTLE);

    vsc_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .tick   (w_tick),
        .expire (w_expire)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (bus.abort)     w_next = ST_IDLE;
                else if (w_expire) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.abort)   w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
                else             w_next = ST_SETTLE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_busy = 1'b0;
        w_vec  = '0;
        case (r_state)
            ST_SETTLE, ST_SAMPLE: begin
                w_busy = 1'b1;
                w_vec  = r_idx;
            end
            default: begin
                w_busy = 1'b0;
                w_vec  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    // done and pass are registered while leaving DONE, so both become
    // visible together in the cycle after the DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_err_cnt <= 5'd0;
            r_resp    <= '0;
            r_pass    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_idx     <= '0;
                r_err_cnt <= 5'd0;
                r_resp    <= '0;
                r_pass    <= 1'b0;
            end else if (w_sample) begin
                r_resp[r_idx] <= bus.y;
                if (w_mismatch) r_err_cnt <= r_err_cnt + 5'd1;
                if (!w_last)    r_idx     <= r_idx + 1'b1;
            end else if (r_state == ST_DONE) begin
                r_pass <= (r_err_cnt == 5'd0);
            end
        end
    end

`ifdef VEC_SEQ_CHK_FIRST_FAIL_EN
    logic [VEC_W-1:0] r_first_fail;
    logic             r_first_fail_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first_fail     <= '0;
            r_first_fail_vld <= 1'b0;
        end else if (w_accept) begin
            r_first_fail     <= '0;
            r_first_fail_vld <= 1'b0;
        end else if (w_sample && w_mismatch && !r_first_fail_vld) begin
            r_first_fail     <= r_idx;
            r_first_fail_vld <= 1'b1;
        end
    end

    assign bus.first_fail     = r_first_fail;
    assign bus.first_fail_vld = r_first_fail_vld;
`else
    assign bus.first_fail     = '0;
    assign bus.first_fail_vld = 1'b0;
`endif

    assign bus.a       = w_vec[3];
    assign bus.b       = w_vec[2];
    assign bus.c       = w_vec[1];
    assign bus.d       = w_vec[0];
    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.err_cnt = r_err_cnt;
    assign bus.resp    = r_resp;

endmodule : vec_seq_chk
`default_nettype wire

// File: tb/tb_vec_seq_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_seq_chk
// Description : Self-checking bench for vec_seq_chk (SETTLE = 2). The y input
//               comes from a small gate model selectable per run: correct
//               gate, tied 0, tied 1, or correct gate with faults at
//               vectors 9 and 13.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_seq_chk;

    typedef struct {
        int          mode;
        bit          repulse;
        logic [15:0] resp;
        logic [4:0]  err;
        logic        pass;
        logic [3:0]  ff;
        logic        ffv;
    } vec_t;

    logic clk;
    logic rst_n;
    int   y_mode;
    logic w_y;
    int   n_checks;
    int   n_err;
    vec_t tbl[4];

    vec_seq_chk_if vif();

    vec_seq_chk #(
        .SETTLE (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate network model: y = ~c & ~(a & d), with optional faults.
    always_comb begin
        logic       gate;
        logic [3:0] vec;
        vec  = {vif.a, vif.b, vif.c, vif.d};
        gate = ~vif.c & ~(vif.a & vif.d);
        w_y  = gate;
        case (y_mode)
            1:       w_y = 1'b0;
            2:       w_y = 1'b1;
            3:       w_y = gate ^ ((vec == 4'd9) || (vec == 4'd13));
            default: w_y = gate;
        endcase
    end
    assign vif.y = w_y;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a run and wait for done; lat counts cycles after the accepting
    // edge. Optionally re-pulses start while busy and during DONE.
    task automatic run(input int m, input bit repulse, output int lat);
        y_mode = m;
        @(negedge clk);
        vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            vif.start = repulse && (lat == 5 || lat == 20 || lat == 48);
            if (vif.done) break;
        end
        vif.start = 1'b0;
    endtask

    // Start a run and stop at cycle 'target' after the accepting edge.
    task automatic start_to(input int m, input int target);
        y_mode = m;
        @(negedge clk);
        vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        repeat (target) @(negedge clk);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (vif.done) n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nd;
        logic [3:0] exp_ff;
        logic       exp_ffv;

        n_checks = 0;
        n_err    = 0;
        tbl[0] = '{mode: 0, repulse: 1'b1, resp: 16'h1133, err: 5'd0,  pass: 1'b1, ff: 4'd0, ffv: 1'b0};
        tbl[1] = '{mode: 1, repulse: 1'b0, resp: 16'h0000, err: 5'd6,  pass: 1'b0, ff: 4'd0, ffv: 1'b1};
        tbl[2] = '{mode: 2, repulse: 1'b0, resp: 16'hFFFF, err: 5'd10, pass: 1'b0, ff: 4'd2, ffv: 1'b1};
        tbl[3] = '{mode: 3, repulse: 1'b0, resp: 16'h3333, err: 5'd2,  pass: 1'b0, ff: 4'd9, ffv: 1'b1};

        rst_n     = 1'b0;
        vif.start = 1'b0;
        vif.abort = 1'b0;
        y_mode    = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_resp", {16'h0, vif.resp}, 32'h0);
        check("reset_misc", {vif.err_cnt, vif.first_fail, vif.busy, vif.done,
                             vif.pass, vif.first_fail_vld, vif.a, vif.b,
                             vif.c, vif.d}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset_busy", {31'h0, vif.busy}, 32'h0);

        // Full runs from the table
        for (int i = 0; i < 4; i++) begin
`ifdef VEC_SEQ_CHK_FIRST_FAIL_EN
            exp_ff  = tbl[i].ff;
            exp_ffv = tbl[i].ffv;
`else
            exp_ff  = 4'd0;
            exp_ffv = 1'b0;
`endif
            run(tbl[i].mode, tbl[i].repulse, lat);
            check($sformatf("run%0d_latency", i), lat, 49);
            check($sformatf("run%0d_resp", i), {16'h0, vif.resp}, {16'h0, tbl[i].resp});
            check($sformatf("run%0d_err_cnt", i), {27'h0, vif.err_cnt}, {27'h0, tbl[i].err});
            check($sformatf("run%0d_pass", i), {31'h0, vif.pass}, {31'h0, tbl[i].pass});
            check($sformatf("run%0d_first_fail", i), {27'h0, vif.first_fail_vld, vif.first_fail},
                  {27'h0, exp_ffv, exp_ff});
            @(negedge clk);
            check($sformatf("run%0d_done_pulse_busy", i), {30'h0, vif.done, vif.busy}, 32'h0);
            repeat (4) @(negedge clk);
            check($sformatf("run%0d_hold", i), {11'h0, vif.err_cnt, vif.resp},
                  {11'h0, tbl[i].err, tbl[i].resp});
            check($sformatf("run%0d_hold_pass", i), {31'h0, vif.pass}, {31'h0, tbl[i].pass});
        end

        // Abort 10 cycles after start (vector 3 in its settle window)
        start_to(0, 10);
        check("abort_mid_vec", {27'h0, vif.busy, vif.a, vif.b, vif.c, vif.d}, 32'h13);
        vif.abort = 1'b1;
        @(negedge clk);
        vif.abort = 1'b0;
        check("abort_mid_idle", {26'h0, vif.busy, vif.done, vif.a, vif.b, vif.c, vif.d}, 32'h0);
        check("abort_mid_pass", {31'h0, vif.pass}, 32'h0);
        count_done(60, nd);
        check("abort_mid_no_done", nd, 0);

        // Abort on the final sample: vector 15 not recorded
        start_to(2, 47);
        check("abort_last_vec", {27'h0, vif.busy, vif.a, vif.b, vif.c, vif.d}, 32'h1F);
        vif.abort = 1'b1;
        @(negedge clk);
        vif.abort = 1'b0;
        check("abort_last_busy", {31'h0, vif.busy}, 32'h0);
        check("abort_last_err_cnt", {27'h0, vif.err_cnt}, 32'd9);
        check("abort_last_resp", {16'h0, vif.resp}, 32'h7FFF);
        count_done(10, nd);
        check("abort_last_no_done", nd, 0);

        // abort and start together in IDLE: stays idle
        @(negedge clk);
        vif.start = 1'b1;
        vif.abort = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        vif.abort = 1'b0;
        check("abort_start_idle", {27'h0, vif.busy, vif.a, vif.b, vif.c, vif.d}, 32'h0);
        count_done(5, nd);
        check("abort_start_no_run", {31'h0, vif.busy} + nd, 32'h0);

        // Asynchronous reset mid-run at vector 7
        start_to(0, 21);
        check("rst_mid_vec", {27'h0, vif.busy, vif.a, vif.b, vif.c, vif.d}, 32'h17);
        rst_n = 1'b0;
        #1;
        check("rst_mid_resp", {16'h0, vif.resp}, 32'h0);
        check("rst_mid_misc", {vif.err_cnt, vif.first_fail, vif.busy, vif.done,
                               vif.pass, vif.first_fail_vld, vif.a, vif.b,
                               vif.c, vif.d}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_restart", {31'h0, vif.busy}, 32'h0);
        run(0, 1'b0, lat);
        check("rst_rerun_latency", lat, 49);
        check("rst_rerun_result", {10'h0, vif.pass, vif.err_cnt, vif.resp},
              {10'h0, 1'b1, 5'd0, 16'h1133});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_vec_seq_chk
`default_nettype wire

// File: doc/vec_seq_chk.md
VEC_SEQ_CHK -- requirements
Module: vec_seq_chk

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the settle cycles between driving a vector and sampling y; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one full 16-vector run.
REQ-005 The block SHALL have port abort, input, 1 bit: terminate the current run.
REQ-006 The block SHALL have port y, input, 1 bit: response of the gate network under test.
REQ-007 The block SHALL have ports a, b, c and d, each an output of 1 bit: stimulus vector bits, MSB first as {a,b,c,d}.
REQ-008 The block SHALL have ports busy, output, 1 bit, and done, output, 1 bit: busy means a run is active; done is a 1-cycle end-of-run pulse.
REQ-009 The block SHALL have port pass, output, 1 bit: err_cnt==0 for the last completed run.
REQ-010 The block SHALL have port err_cnt, output, 5 bits: mismatch count, 0..16.
REQ-011 The block SHALL have port resp, output, 16 bits: sampled y per index, where bit i is the y sampled for vector i.
REQ-012 The block SHALL have ports first_fail, output, 4 bits, and first_fail_vld, output, 1 bit: index of the first mismatch and its valid flag.

Function
REQ-013 The block SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE, start=1 and abort=0 at an edge SHALL set idx=0, clear err_cnt/resp/first_fail*/pass, and enter SETTLE.
REQ-015 {a,b,c,d} SHALL equal idx while in SETTLE or SAMPLE, and SHALL be 4'b0000 otherwise.
REQ-016 SETTLE SHALL last exactly SETTLE cycles, using a settle counter, then go to SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle, in which it writes resp[idx]=y and increments err_cnt if y != GOLDEN[idx].
REQ-018 From SAMPLE, if idx==15 the FSM SHALL go to DONE; otherwise it SHALL set idx=idx+1 and return to SETTLE.
REQ-019 DONE SHALL last 1 cycle with done=1 and pass updated, then go to IDLE.
REQ-020 With start accepted at edge k, done SHALL be high in the cycle after edge k+16*(SETTLE+1)+1; SETTLE=2 gives 49 cycles.
REQ-021 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored while busy=1 or in DONE.
REQ-023 abort=1 in SETTLE or SAMPLE SHALL return the FSM to IDLE at the next edge with no done pulse, leave pass unchanged, and drive a..d to 0.
REQ-024 If abort=1 and start=1 in the same IDLE cycle, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-025 If abort coincides with the final SAMPLE, abort SHALL win and neither err_cnt nor resp bit 15 SHALL be updated.
REQ-026 err_cnt SHALL be 5 bits so that 16 mismatches never wrap.
REQ-027 resp, err_cnt, pass and first_fail* SHALL hold their values after DONE until the next accepted start.

Reset
REQ-028 rst_n=0 SHALL immediately force the FSM to IDLE and idx, counters, a..d, busy, done, pass, err_cnt, resp, first_fail and first_fail_vld to 0, including mid-run.
REQ-029 After rst_n rises, the block SHALL require a fresh start before beginning a run.

Configuration
REQ-030 With VEC_SEQ_CHK_FIRST_FAIL_EN defined, the first mismatching SAMPLE SHALL latch first_fail=idx and first_fail_vld=1, and later mismatches SHALL not overwrite them.
REQ-031 Without VEC_SEQ_CHK_FIRST_FAIL_EN, the first_fail and first_fail_vld ports SHALL still exist but SHALL be tied to 0, with no capture logic synthesized.

Structure
REQ-032 Package vec_seq_chk_pkg SHALL hold the FSM state enum, VEC_W=4, NUM_VEC=16 and GOLDEN=16'h1133, where GOLDEN is y = ~c & ~(a&d) indexed by {a,b,c,d}.
REQ-033 The settle counter SHALL be a sub-module named vsc_settle_cnt with load, tick and expire signals; all other logic SHALL be flat.

Verification
REQ-034 With SETTLE=2 and y driven by a correct gate model: start -> done 49 cycles later, resp=16'h1133, err_cnt=0, pass=1, first_fail_vld=0.
REQ-035 With y tied 0: err_cnt=6, resp=16'h0000, pass=0, first_fail=0 when the macro is on.
REQ-036 With y tied 1: err_cnt=10, resp=16'hFFFF, pass=0, first_fail=2 when the macro is on.
REQ-037 With abort pulsed 10 cycles after start: no done pulse, busy=0 next cycle, a..d=0, and pass keeps its prior value.
REQ-038 With rst_n pulsed low mid-run at idx=7: all outputs read 0 before the next clock edge, and a subsequent start runs a full pass.
REQ-039 With start re-pulsed while busy and abort+start asserted together in IDLE: run timing is unchanged and the FSM stays in IDLE respectively.
